// File: rtl/e_mul_div_unit.sv
// E-stage multiply/divide unit with private HI/LO and a busy counter modelling latency.
// Optional: define MDU_DIV0_KEEP_EN to make divide-by-zero a one-cycle no-op.
module e_mul_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUOp,
    input  logic [31:0] E_TrueALUA,
    input  logic [31:0] E_TrueALUB,
    input  logic        Req,
    output logic        E_Start,
    output logic        E_Busy,
    output logic [31:0] E_MDUOut
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 2) ? $clog2(MaxCycles) : 1;

`ifdef MDU_DIV0_KEEP_EN
    localparam bit Div0Keep = 1'b1;
`else
    localparam bit Div0Keep = 1'b0;
`endif

    typedef enum logic {StIdle, StBusy} stateType;

    stateType        state;
    logic [CntW-1:0] busyCnt;
    logic [31:0]     hiReg;
    logic [31:0]     loReg;
    logic [63:0]     pendingRes;

    logic        isMulDiv;
    logic        isDiv;
    logic        divByZero;
    logic        divOverflow;
    logic        skipStart;
    logic [63:0] result;
    logic signed [31:0] sQuot;
    logic signed [31:0] sRem;
    logic [31:0] uQuot;
    logic [31:0] uRem;

    assign isMulDiv    = (E_MDUOp >= 4'd1) && (E_MDUOp <= 4'd4);
    assign isDiv       = (E_MDUOp == 4'd3) || (E_MDUOp == 4'd4);
    assign divByZero   = (E_TrueALUB == 32'h0);
    assign divOverflow = (E_TrueALUA == 32'h8000_0000) && (E_TrueALUB == 32'hFFFF_FFFF);
    assign skipStart   = Div0Keep && isDiv && divByZero;

    assign E_Start = isMulDiv && (state == StIdle) && !Req;
    assign E_Busy  = (state == StBusy);

    // Zero and overflow divisors are muxed away below, so these raw quotients never escape.
    assign sQuot = $signed(E_TrueALUA) / $signed(E_TrueALUB);
    assign sRem  = $signed(E_TrueALUA) % $signed(E_TrueALUB);
    assign uQuot = E_TrueALUA / E_TrueALUB;
    assign uRem  = E_TrueALUA % E_TrueALUB;

    always_comb begin
        result = '0;
        case (E_MDUOp)
            4'd1: result = {{32{E_TrueALUA[31]}}, E_TrueALUA} * {{32{E_TrueALUB[31]}}, E_TrueALUB};
            4'd2: result = {32'h0, E_TrueALUA} * {32'h0, E_TrueALUB};
            4'd3: begin
                if (divByZero)        result = {E_TrueALUA, 32'hFFFF_FFFF};
                else if (divOverflow) result = {32'h0, E_TrueALUA};
                else                  result = {sRem, sQuot};
            end
            4'd4: begin
                if (divByZero) result = {E_TrueALUA, 32'hFFFF_FFFF};
                else           result = {uRem, uQuot};
            end
            default: result = '0;
        endcase
    end

    always_comb begin
        case (E_MDUOp)
            4'd5:    E_MDUOut = hiReg;
            4'd6:    E_MDUOut = loReg;
            default: E_MDUOut = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            busyCnt    <= '0;
            hiReg      <= '0;
            loReg      <= '0;
            pendingRes <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (E_Start) begin
                        if (!skipStart) begin
                            pendingRes <= result;
                            busyCnt    <= isDiv ? CntW'(DIV_CYCLES - 1) : CntW'(MULT_CYCLES - 1);
                            state      <= StBusy;
                        end
                    end else if (!Req) begin
                        if (E_MDUOp == 4'd7) hiReg <= E_TrueALUA;
                        if (E_MDUOp == 4'd8) loReg <= E_TrueALUA;
                    end
                end
                StBusy: begin
                    // Req never cancels here: the in-flight op belongs to a committed instruction.
                    if (busyCnt != '0) begin
                        busyCnt <= busyCnt - CntW'(1);
                    end else begin
                        hiReg <= pendingRes[63:32];
                        loReg <= pendingRes[31:0];
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/e_mul_div_unit.md
Name: e_mul_div_unit

Overview:
- Execute-stage multiply/divide unit with its own HI/LO register pair.
- Consumes the forwarded E-stage operands E_TrueALUA and E_TrueALUB, the outputs of the E-stage forwarding muxes.
- Models multi-cycle mult/div latency with a busy counter. The hazard unit uses E_Start/E_Busy to stall D-stage MDU instructions.
- Serves mfhi/mflo reads combinationally and mthi/mtlo writes in one cycle.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- E_MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; other codes are treated as none.
- E_TrueALUA  input  32  forwarded rs operand.
- E_TrueALUB  input  32  forwarded rt operand.
- Req  input  1  exception/interrupt request from CP0; suppresses architectural updates this cycle.
- E_Start  output  1  combinational; high when E_MDUOp is 1-4, E_Busy=0 and Req=0.
- E_Busy  output  1  registered; high while an operation is in flight.
- E_MDUOut  output  32  combinational; HI when op=5, LO when op=6, else 0.

Behaviour:
- Reset is synchronous. Next edge with reset=1 sets HI=0, LO=0, E_Busy=0, counter=0, and clears the pending result.
- Reset mid-operation aborts the operation; HI/LO are not updated.
- Start: at an edge where E_Start=1:
  - Latch the op and both operands.
  - Compute the 64-bit result into a pending register.
  - Load counter with N-1 (N = MULT_CYCLES or DIV_CYCLES); set E_Busy=1.
- Busy phase:
  - Each edge with E_Busy=1 and counter>0 decrements the counter.
  - At the edge with counter=0: HI/LO take the pending result and E_Busy falls.
  - E_Busy is therefore high exactly N cycles. New HI/LO are visible to mfhi/mflo in the cycle E_Busy is first low.
- Arithmetic:
  - mult: signed 32x32 to 64; HI=[63:32], LO=[31:0]. multu: the same, unsigned.
  - div: LO=signed quotient truncated toward zero; HI=remainder with the dividend's sign.
  - divu: unsigned quotient and remainder.
  - 0x80000000 div 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero: see Optional Feature.
- mthi/mtlo: at an edge with E_Busy=0 and Req=0, HI (or LO) takes E_TrueALUA. With E_Busy=1 or Req=1 the write is ignored.
- mfhi/mflo read the HI/LO registers, not the pending result. Reads during busy return old values; the hazard unit stalls them.
- MDU op while busy: E_Start=0 and the op is ignored (no restart, no queueing). The hazard unit normally prevents this.
- Req while busy: the in-flight operation is not cancelled; it belongs to an older, committed instruction.
- Req on a start cycle: the start is suppressed.
- E_MDUOut is 0 for every op other than 5 and 6.

Optional Feature:
- Macro MDU_DIV0_KEEP_EN.
- Defined: div/divu with E_TrueALUB=0 leaves HI/LO unchanged. E_Start still pulses but E_Busy stays 0, so the op costs one cycle.
- Undefined: divide by zero runs the full DIV_CYCLES and writes HI=dividend, LO=0xFFFFFFFF, for both signed and unsigned.

Test Plan:
- Reset, then mult A=0xFFFFFFFF B=0x00000002 at edge T:
  - E_Busy high for 5 cycles, HI/LO update at T+5.
  - Result: HI=0xFFFFFFFF, LO=0xFFFFFFFE; mfhi/mflo in the next cycle return these values.
- multu with the same operands: HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2: E_Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 gives LO=3, HI=1.
- mthi 0x12345678 issued while busy: ignored, and HI equals the mult result afterwards. mtlo 0xCAFEBABE while idle: LO=0xCAFEBABE at the next edge. mult with Req=1: E_Start=0, E_Busy stays 0, HI/LO unchanged.
- reset asserted 3 cycles into a div: at the next edge E_Busy=0, HI=LO=0, and no later update occurs.
- div 5/0:
  - With MDU_DIV0_KEEP_EN: E_Busy never rises and HI/LO are unchanged.
  - Without it: after 10 cycles HI=5, LO=0xFFFFFFFF.
